// File: rtl/seq_packet_packer.sv
`default_nettype none
// ============================================================================
// Module   : seq_packet_packer
// Purpose  : Packs one-per-handshake sequences into SEQ_PACKET_SIZE-lane
//            packets with an accumulation buffer and an output register.
//            Optional idle force-close enabled by SEQ_PACKER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module seq_packet_packer #(
    parameter int SEQ_PACKET_SIZE = 4,
    parameter int SEQ_LL_BITS     = 16,
    parameter int SEQ_ML_BITS     = 16,
    parameter int SEQ_OFFSET_BITS = 16,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        i_valid,
    output logic                                        i_ready,
    input  logic [SEQ_LL_BITS-1:0]                      i_ll,
    input  logic [SEQ_ML_BITS-1:0]                      i_ml,
    input  logic [SEQ_OFFSET_BITS-1:0]                  i_offset,
    input  logic [SEQ_ML_BITS-1:0]                      i_overlap,
    input  logic                                        i_eoj,
    input  logic                                        i_delim,
    output logic                                        o_valid,
    input  logic                                        o_ready,
    output logic [SEQ_PACKET_SIZE-1:0]                  o_strb,
    output logic [SEQ_LL_BITS*SEQ_PACKET_SIZE-1:0]      o_ll,
    output logic [SEQ_ML_BITS*SEQ_PACKET_SIZE-1:0]      o_ml,
    output logic [SEQ_OFFSET_BITS*SEQ_PACKET_SIZE-1:0]  o_offset,
    output logic [SEQ_ML_BITS*SEQ_PACKET_SIZE-1:0]      o_overlap,
    output logic [SEQ_PACKET_SIZE-1:0]                  o_eoj,
    output logic [SEQ_PACKET_SIZE-1:0]                  o_delim
);

    localparam int c_N     = SEQ_PACKET_SIZE;
    localparam int c_CNT_W = (c_N > 1) ? $clog2(c_N) : 1;
    localparam int c_LL_W  = SEQ_LL_BITS * c_N;
    localparam int c_ML_W  = SEQ_ML_BITS * c_N;
    localparam int c_OF_W  = SEQ_OFFSET_BITS * c_N;

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_valid;

    logic [c_N-1:0]     r_acc_strb, r_acc_eoj, r_acc_delim;
    logic [c_LL_W-1:0]  r_acc_ll;
    logic [c_ML_W-1:0]  r_acc_ml, r_acc_ov;
    logic [c_OF_W-1:0]  r_acc_off;

    logic [c_N-1:0]     r_out_strb, r_out_eoj, r_out_delim;
    logic [c_LL_W-1:0]  r_out_ll;
    logic [c_ML_W-1:0]  r_out_ml, r_out_ov;
    logic [c_OF_W-1:0]  r_out_off;

    logic [c_N-1:0]     w_pkt_strb, w_pkt_eoj, w_pkt_delim;
    logic [c_LL_W-1:0]  w_pkt_ll;
    logic [c_ML_W-1:0]  w_pkt_ml, w_pkt_ov;
    logic [c_OF_W-1:0]  w_pkt_off;

    logic w_accept, w_last_lane, w_timeout, w_close;

    assign i_ready     = !r_valid || o_ready;
    assign w_accept    = i_valid && i_ready;
    assign w_last_lane = (r_cnt == c_CNT_W'(c_N - 1));
    assign w_close     = (w_accept && (w_last_lane || i_eoj)) || w_timeout;

    // Accumulated lanes with the incoming sequence merged into lane r_cnt;
    // this is both the next accumulation state and the closing packet.
    always_comb begin
        w_pkt_strb  = r_acc_strb;
        w_pkt_eoj   = r_acc_eoj;
        w_pkt_delim = r_acc_delim;
        w_pkt_ll    = r_acc_ll;
        w_pkt_ml    = r_acc_ml;
        w_pkt_ov    = r_acc_ov;
        w_pkt_off   = r_acc_off;
        if (w_accept) begin
            for (int k = 0; k < c_N; k++) begin
                if (r_cnt == c_CNT_W'(k)) begin
                    w_pkt_strb[k]                                   = 1'b1;
                    w_pkt_eoj[k]                                    = i_eoj;
                    w_pkt_delim[k]                                  = i_delim;
                    w_pkt_ll[k*SEQ_LL_BITS +: SEQ_LL_BITS]          = i_ll;
                    w_pkt_ml[k*SEQ_ML_BITS +: SEQ_ML_BITS]          = i_ml;
                    w_pkt_ov[k*SEQ_ML_BITS +: SEQ_ML_BITS]          = i_overlap;
                    w_pkt_off[k*SEQ_OFFSET_BITS +: SEQ_OFFSET_BITS] = i_offset;
                end
            end
        end
    end

    // Zero or negative timeouts are meaningless; this block only documents the range.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
    end

`ifdef SEQ_PACKER_TIMEOUT_EN
    localparam int                  c_IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(TIMEOUT_CYCLES - 1);

    logic [c_IDLE_W-1:0] r_idle;
    logic                w_partial;

    assign w_partial = (r_cnt != '0);
    // Fires on the idle cycle that would bring the count to TIMEOUT_CYCLES;
    // saturates there while the output register is still occupied.
    assign w_timeout = w_partial && !w_accept && i_ready && (r_idle == c_IDLE_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idle <= '0;
        end else if (w_accept || w_close) begin
            r_idle <= '0;
        end else if (w_partial && (r_idle != c_IDLE_LAST)) begin
            r_idle <= r_idle + c_IDLE_W'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_valid     <= 1'b0;
            r_acc_strb  <= '0;
            r_acc_eoj   <= '0;
            r_acc_delim <= '0;
            r_acc_ll    <= '0;
            r_acc_ml    <= '0;
            r_acc_ov    <= '0;
            r_acc_off   <= '0;
            r_out_strb  <= '0;
            r_out_eoj   <= '0;
            r_out_delim <= '0;
            r_out_ll    <= '0;
            r_out_ml    <= '0;
            r_out_ov    <= '0;
            r_out_off   <= '0;
        end else if (w_close) begin
            r_valid     <= 1'b1;
            r_out_strb  <= w_pkt_strb;
            r_out_eoj   <= w_pkt_eoj;
            r_out_delim <= w_pkt_delim;
            r_out_ll    <= w_pkt_ll;
            r_out_ml    <= w_pkt_ml;
            r_out_ov    <= w_pkt_ov;
            r_out_off   <= w_pkt_off;
            r_cnt       <= '0;
            r_acc_strb  <= '0;
            r_acc_eoj   <= '0;
            r_acc_delim <= '0;
            r_acc_ll    <= '0;
            r_acc_ml    <= '0;
            r_acc_ov    <= '0;
            r_acc_off   <= '0;
        end else begin
            if (o_ready) begin
                r_valid <= 1'b0;
            end
            if (w_accept) begin
                r_cnt       <= r_cnt + c_CNT_W'(1);
                r_acc_strb  <= w_pkt_strb;
                r_acc_eoj   <= w_pkt_eoj;
                r_acc_delim <= w_pkt_delim;
                r_acc_ll    <= w_pkt_ll;
                r_acc_ml    <= w_pkt_ml;
                r_acc_ov    <= w_pkt_ov;
                r_acc_off   <= w_pkt_off;
            end
        end
    end

    assign o_valid   = r_valid;
    assign o_strb    = r_out_strb;
    assign o_eoj     = r_out_eoj;
    assign o_delim   = r_out_delim;
    assign o_ll      = r_out_ll;
    assign o_ml      = r_out_ml;
    assign o_overlap = r_out_ov;
    assign o_offset  = r_out_off;

endmodule
`default_nettype wire

// File: tb/tb_seq_packet_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_packet_packer
// Purpose  : Self-checking bench: queue-based packet model compared every
//            cycle, plus directed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_packet_packer;

    localparam int c_N   = 4;
    localparam int c_W   = 16;
    localparam int c_TMO = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_valid, i_ready, i_eoj, i_delim;
    logic [c_W-1:0]    i_ll, i_ml, i_offset, i_overlap;
    logic              o_valid, o_ready;
    logic [c_N-1:0]    o_strb, o_eoj, o_delim;
    logic [c_W*c_N-1:0] o_ll, o_ml, o_offset, o_overlap;

    seq_packet_packer #(
        .SEQ_PACKET_SIZE (c_N),
        .SEQ_LL_BITS     (c_W),
        .SEQ_ML_BITS     (c_W),
        .SEQ_OFFSET_BITS (c_W),
        .TIMEOUT_CYCLES  (c_TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (i_valid),
        .i_ready   (i_ready),
        .i_ll      (i_ll),
        .i_ml      (i_ml),
        .i_offset  (i_offset),
        .i_overlap (i_overlap),
        .i_eoj     (i_eoj),
        .i_delim   (i_delim),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .o_strb    (o_strb),
        .o_ll      (o_ll),
        .o_ml      (o_ml),
        .o_offset  (o_offset),
        .o_overlap (o_overlap),
        .o_eoj     (o_eoj),
        .o_delim   (o_delim)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Model: pending sequences of the open packet, plus the packet on the output.
    typedef struct packed {
        logic [c_W-1:0] ll, ml, off, ov;
        logic           eoj, delim;
    } seq_t;

    seq_t               m_q[$];
    logic               m_valid = 1'b0;
    logic [c_N-1:0]     m_strb = '0, m_eoj = '0, m_delim = '0;
    logic [c_W*c_N-1:0] m_ll = '0, m_ml = '0, m_off = '0, m_ov = '0;
    int                 m_idle = 0;

    task automatic model_step();
        bit   rdy, acc, close;
        seq_t s;
        rdy = !m_valid || o_ready;
        if (rst) begin
            m_q.delete();
            m_valid = 1'b0; m_idle = 0;
            m_strb = '0; m_eoj = '0; m_delim = '0;
            m_ll = '0; m_ml = '0; m_off = '0; m_ov = '0;
        end else begin
            acc   = i_valid && rdy;
            close = 1'b0;
            if (acc) begin
                s.ll = i_ll; s.ml = i_ml; s.off = i_offset; s.ov = i_overlap;
                s.eoj = i_eoj; s.delim = i_delim;
                m_q.push_back(s);
                close = (m_q.size() == c_N) || i_eoj;
            end
`ifdef SEQ_PACKER_TIMEOUT_EN
            if (!acc && m_q.size() > 0 && rdy && (m_idle + 1 >= c_TMO)) close = 1'b1;
            if (acc || close) m_idle = 0;
            else if (m_q.size() > 0) m_idle++;
`endif
            if (close) begin
                m_strb = '0; m_eoj = '0; m_delim = '0;
                m_ll = '0; m_ml = '0; m_off = '0; m_ov = '0;
                for (int k = 0; k < m_q.size(); k++) begin
                    m_strb[k]          = 1'b1;
                    m_eoj[k]           = m_q[k].eoj;
                    m_delim[k]         = m_q[k].delim;
                    m_ll[k*c_W +: c_W]  = m_q[k].ll;
                    m_ml[k*c_W +: c_W]  = m_q[k].ml;
                    m_off[k*c_W +: c_W] = m_q[k].off;
                    m_ov[k*c_W +: c_W]  = m_q[k].ov;
                end
                m_q.delete();
                m_valid = 1'b1;
            end else if (m_valid && o_ready) begin
                m_valid = 1'b0;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (checking) begin
                chk("i_ready",   {63'd0, i_ready}, {63'd0, (!m_valid || o_ready)});
                chk("o_valid",   {63'd0, o_valid}, {63'd0, m_valid});
                chk("o_strb",    {60'd0, o_strb},  {60'd0, m_strb});
                chk("o_eoj",     {60'd0, o_eoj},   {60'd0, m_eoj});
                chk("o_delim",   {60'd0, o_delim}, {60'd0, m_delim});
                chk("o_ll",      o_ll,      m_ll);
                chk("o_ml",      o_ml,      m_ml);
                chk("o_offset",  o_offset,  m_off);
                chk("o_overlap", o_overlap, m_ov);
            end
            model_step();
        end
    end

    task automatic send(input int ll, input int ml, input int off, input int ov,
                        input bit eoj, input bit delim);
        bit ok = 1'b0;
        i_ll = ll[c_W-1:0]; i_ml = ml[c_W-1:0];
        i_offset = off[c_W-1:0]; i_overlap = ov[c_W-1:0];
        i_eoj = eoj; i_delim = delim; i_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (i_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_total++;
            $display("FAIL send_accept: got i_ready=0 for 50 cycles expected acceptance");
        end
        @(posedge clk); #1;
        i_valid = 1'b0; i_eoj = 1'b0; i_delim = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        repeat (5000) @(posedge clk);
        $display("FAIL watchdog: got no finish expected end within 5000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_eoj = 1'b0; i_delim = 1'b0;
        i_ll = '0; i_ml = '0; i_offset = '0; i_overlap = '0; o_ready = 1'b1;
        @(posedge clk); #1;
        checking = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Two full packets, o_ready held high.
        for (int i = 1; i <= 8; i++) begin
            send(i, 0, 0, 0, 1'b0, 1'b0);
            if (i == 3) chk("t1_no_early_valid", {63'd0, o_valid}, 64'd0);
            if (i == 4) begin
                chk("t1_valid_after_4th", {63'd0, o_valid}, 64'd1);
                chk("t1_strb0", {60'd0, o_strb}, 64'hF);
                chk("t1_ll0", o_ll, 64'h0004_0003_0002_0001);
            end
            if (i == 8) chk("t1_ll1", o_ll, 64'h0008_0007_0006_0005);
        end
        repeat (2) @(posedge clk); #1;

        // eoj closes a 3-lane packet.
        send(1, 7, 101, 0, 1'b0, 1'b0);
        send(2, 8, 102, 0, 1'b0, 1'b0);
        send(3, 9, 103, 0, 1'b1, 1'b0);
        chk("t2_strb", {60'd0, o_strb}, 64'h7);
        chk("t2_eoj",  {60'd0, o_eoj},  64'h4);
        chk("t2_ml",   o_ml, 64'h0000_0009_0008_0007);
        repeat (2) @(posedge clk); #1;

        // Downstream stall with sequences still offered.
        o_ready = 1'b0;
        fork
            for (int i = 0; i < 8; i++) send(20 + i, 30 + i, 1000 + i, i, 1'b0, 1'b0);
            begin
                repeat (10) @(posedge clk); #1;
                chk("t3_held_valid", {63'd0, o_valid}, 64'd1);
                chk("t3_held_ready", {63'd0, i_ready}, 64'd0);
                chk("t3_held_ll", o_ll, 64'h0017_0016_0015_0014);
                o_ready = 1'b1;
            end
        join
        repeat (2) @(posedge clk); #1;

        // delim is carried per lane and does not close.
        send(1, 1, 1, 1, 1'b0, 1'b0);
        send(2, 2, 2, 2, 1'b0, 1'b1);
        chk("t4_no_close", {63'd0, o_valid}, 64'd0);
        send(3, 3, 3, 3, 1'b0, 1'b0);
        send(4, 4, 4, 4, 1'b0, 1'b0);
        chk("t4_strb",  {60'd0, o_strb},  64'hF);
        chk("t4_delim", {60'd0, o_delim}, 64'h2);
        chk("t4_eoj",   {60'd0, o_eoj},   64'h0);
        repeat (2) @(posedge clk); #1;

        // Reset with a partial packet, then restart at lane 0.
        send(91, 0, 0, 0, 1'b0, 1'b0);
        send(92, 0, 0, 0, 1'b0, 1'b0);
        pulse_reset();
        for (int i = 0; i < 4; i++) send(41 + i, 0, 0, 0, 1'b0, 1'b0);
        chk("t5_strb", {60'd0, o_strb}, 64'hF);
        chk("t5_ll",   o_ll, 64'h002C_002B_002A_0029);
        repeat (2) @(posedge clk); #1;

        // Reset with a pending output packet.
        o_ready = 1'b0;
        send(55, 5, 5, 5, 1'b1, 1'b0);
        chk("t5_pending", {63'd0, o_valid}, 64'd1);
        pulse_reset();
        chk("t5_rst_valid", {63'd0, o_valid}, 64'd0);
        chk("t5_rst_ll",    o_ll, 64'd0);
        chk("t5_rst_strb",  {60'd0, o_strb}, 64'd0);
        o_ready = 1'b1;
        repeat (2) @(posedge clk); #1;

`ifdef SEQ_PACKER_TIMEOUT_EN
        send(61, 0, 0, 0, 1'b0, 1'b0);
        send(62, 0, 0, 0, 1'b0, 1'b0);
        repeat (4) @(posedge clk); #1;
        chk("t6_not_yet", {63'd0, o_valid}, 64'd0);
        @(posedge clk); #1;
        chk("t6_valid", {63'd0, o_valid}, 64'd1);
        chk("t6_strb",  {60'd0, o_strb},  64'h3);
        chk("t6_eoj",   {60'd0, o_eoj},   64'h0);
        repeat (2) @(posedge clk); #1;
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
